// File: rtl/smg_decoder_module.sv
// -----------------------------------------------------------------------------
// smg_decoder_module
// Receive-side monitor for a time-multiplexed, active-low, 2-digit
// seven-segment bus. It recovers the tens and ones BCD digits, filters each
// digit for stability before committing it, flags illegal patterns and select
// conflicts, and detects a digit that has stopped being scanned.
//
// Ports
//   CLK          in   system clock, rising edge
//   RSTn         in   asynchronous active-low reset
//   SMG_Data     in   [7:0] segment byte, active-low; bit7 = DP (ignored)
//   Scan_Sig     in   [1:0] active-low digit select (bit1 tens, bit0 ones)
//   Ten_Data     out  [3:0] committed tens digit
//   One_Data     out  [3:0] committed ones digit
//   Data_Valid   out  both digits committed since reset / last scan loss
//   Err_Invalid  out  one-cycle pulse after an illegal pattern or conflict
//   Scan_Lost    out  a digit has not been sampled for TIMEOUT cycles
// -----------------------------------------------------------------------------
module smg_decoder_module #(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [7:0] SMG_Data,
    input  logic [1:0] Scan_Sig,
    output logic [3:0] Ten_Data,
    output logic [3:0] One_Data,
    output logic       Data_Valid,
    output logic       Err_Invalid,
    output logic       Scan_Lost
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    STABLE_L  = 4'(STABLE_CNT);
    localparam logic [TW-1:0] TIMEOUT_L = TW'(TIMEOUT);

    // Index 1 = tens digit, index 0 = ones digit (matches Scan_Sig bit order).
    logic [1:0][3:0]    cand_q, cand_d;
    logic [1:0][3:0]    cnt_q,  cnt_d;
    logic [1:0][3:0]    out_q,  out_d;
    logic [1:0][TW-1:0] tmr_q,  tmr_d;
    logic [1:0]         cmt_q,  cmt_d;
    logic [1:0]         lost_q, lost_d;
    logic               dv_q,   dv_d;
    logic               err_q,  err_d;
    logic               scan_lost_q, scan_lost_d;

    logic [4:0] dec_s;
    logic       legal_s;
    logic [3:0] val_s;
    logic       conflict_s;
    logic [1:0] smp_s;

    // Map a segment byte to {legal, digit}; the DP bit is a don't-care.
    function automatic logic [4:0] seg_decode(input logic [7:0] seg);
        logic [4:0] r;
        casez (seg)
            8'b?100_0000: r = 5'h10;
            8'b?111_1001: r = 5'h11;
            8'b?010_0100: r = 5'h12;
            8'b?011_0000: r = 5'h13;
            8'b?001_1001: r = 5'h14;
            8'b?001_0010: r = 5'h15;
            8'b?000_0010: r = 5'h16;
            8'b?111_1000: r = 5'h17;
            8'b?000_0000: r = 5'h18;
            8'b?001_0000: r = 5'h19;
            default:      r = 5'h00;
        endcase
        return r;
    endfunction

    // Sample classification and per-digit filter / timer next-state logic.
    always_comb begin
        dec_s      = seg_decode(SMG_Data);
        legal_s    = dec_s[4];
        val_s      = dec_s[3:0];
        conflict_s = (Scan_Sig == 2'b00);
        smp_s[1]   = (Scan_Sig == 2'b01);
        smp_s[0]   = (Scan_Sig == 2'b10);
        err_d      = conflict_s | ((smp_s[1] | smp_s[0]) & ~legal_s);

        cand_d = cand_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        tmr_d  = tmr_q;
        cmt_d  = cmt_q;
        lost_d = lost_q;

        for (int d = 0; d < 2; d++) begin
            if (smp_s[d]) begin
                // Any sample of this digit, legal or not, proves it is scanned.
                tmr_d[d]  = {TW{1'b0}};
                lost_d[d] = 1'b0;
                if (legal_s) begin
                    if ((cnt_q[d] != 4'd0) && (val_s == cand_q[d])) begin
                        if (cnt_q[d] < STABLE_L) begin
                            cnt_d[d] = cnt_q[d] + 4'd1;
                        end else begin
                            cnt_d[d] = cnt_q[d];
                        end
                    end else begin
                        cand_d[d] = val_s;
                        cnt_d[d]  = 4'd1;
                    end
                    // Re-commit while saturated is harmless: the value is unchanged.
                    if (cnt_d[d] == STABLE_L) begin
                        out_d[d] = cand_d[d];
                        cmt_d[d] = 1'b1;
                    end else begin
                        out_d[d] = out_q[d];
                    end
                end else begin
                    cnt_d[d] = 4'd0;
                end
            end else if (conflict_s) begin
                // Conflicting selects freeze everything, timers included.
                tmr_d[d] = tmr_q[d];
            end else begin
                if (tmr_q[d] < TIMEOUT_L) begin
                    tmr_d[d] = tmr_q[d] + TW'(1);
                end else begin
                    tmr_d[d] = tmr_q[d];
                end
                // Fires once, on the edge the timer reaches TIMEOUT; outputs hold.
                if (tmr_q[d] == (TIMEOUT_L - TW'(1))) begin
                    lost_d[d] = 1'b1;
                    cmt_d[d]  = 1'b0;
                    cnt_d[d]  = 4'd0;
                    cand_d[d] = 4'd0;
                end else begin
                    lost_d[d] = lost_q[d];
                end
            end
        end

        // Uses the registered commit flags so Data_Valid trails the later
        // commit by one cycle, but drops on the very edge a loss is declared.
        dv_d        = cmt_q[1] & cmt_q[0] & ~lost_d[1] & ~lost_d[0];
        scan_lost_d = lost_d[1] | lost_d[0];
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cand_q      <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            tmr_q       <= '0;
            cmt_q       <= 2'b00;
            lost_q      <= 2'b00;
            dv_q        <= 1'b0;
            err_q       <= 1'b0;
            scan_lost_q <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            tmr_q       <= tmr_d;
            cmt_q       <= cmt_d;
            lost_q      <= lost_d;
            dv_q        <= dv_d;
            err_q       <= err_d;
            scan_lost_q <= scan_lost_d;
        end
    end

    assign Ten_Data    = out_q[1];
    assign One_Data    = out_q[0];
    assign Data_Valid  = dv_q;
    assign Err_Invalid = err_q;
    assign Scan_Lost   = scan_lost_q;

endmodule

// File: tb/tb_smg_decoder_module.sv
// -----------------------------------------------------------------------------
// tb_smg_decoder_module
// Directed scoreboard bench. Each stimulus step pushes the expected outputs
// for the edge that samples it; a monitor pops and compares after each edge.
// Instance A: STABLE_CNT=4, TIMEOUT=16. Instance B: STABLE_CNT=1, TIMEOUT=16.
// -----------------------------------------------------------------------------
module tb_smg_decoder_module;

    logic       CLK;
    logic       rsta_n;
    logic       rstb_n;
    logic [7:0] SMG_Data;
    logic [1:0] Scan_Sig;

    logic [3:0] a_ten, a_one, b_ten, b_one;
    logic       a_dv, a_err, a_lost, b_dv, b_err, b_lost;

    typedef struct packed {
        logic        dut;
        logic [3:0]  ten;
        logic [3:0]  one;
        logic        dv;
        logic        err;
        logic        lost;
        logic [15:0] id;
    } exp_t;

    exp_t sq[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;

    smg_decoder_module #(.STABLE_CNT(4), .TIMEOUT(16)) u_a (
        .CLK(CLK), .RSTn(rsta_n), .SMG_Data(SMG_Data), .Scan_Sig(Scan_Sig),
        .Ten_Data(a_ten), .One_Data(a_one), .Data_Valid(a_dv),
        .Err_Invalid(a_err), .Scan_Lost(a_lost)
    );

    smg_decoder_module #(.STABLE_CNT(1), .TIMEOUT(16)) u_b (
        .CLK(CLK), .RSTn(rstb_n), .SMG_Data(SMG_Data), .Scan_Sig(Scan_Sig),
        .Ten_Data(b_ten), .One_Data(b_one), .Data_Valid(b_dv),
        .Err_Invalid(b_err), .Scan_Lost(b_lost)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d expected=%0d", nm, id, act, exp);
        end
    endtask

    // Monitor: one expectation per sampling edge, compared 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sq.size() != 0) begin
                e = sq.pop_front();
                if (e.dut) begin
                    chk("b_ten",  int'(e.id), int'(b_ten),  int'(e.ten));
                    chk("b_one",  int'(e.id), int'(b_one),  int'(e.one));
                    chk("b_dv",   int'(e.id), int'(b_dv),   int'(e.dv));
                    chk("b_err",  int'(e.id), int'(b_err),  int'(e.err));
                    chk("b_lost", int'(e.id), int'(b_lost), int'(e.lost));
                end else begin
                    chk("a_ten",  int'(e.id), int'(a_ten),  int'(e.ten));
                    chk("a_one",  int'(e.id), int'(a_one),  int'(e.one));
                    chk("a_dv",   int'(e.id), int'(a_dv),   int'(e.dv));
                    chk("a_err",  int'(e.id), int'(a_err),  int'(e.err));
                    chk("a_lost", int'(e.id), int'(a_lost), int'(e.lost));
                end
            end
        end
    end

    task automatic step(input logic [1:0] sel, input logic [7:0] dat,
                        input logic [3:0] t, input logic [3:0] o,
                        input logic v, input logic e, input logic l,
                        input logic which);
        exp_t x;
        @(negedge CLK);
        Scan_Sig = sel;
        SMG_Data = dat;
        step_id++;
        x.dut  = which;
        x.ten  = t;
        x.one  = o;
        x.dv   = v;
        x.err  = e;
        x.lost = l;
        x.id   = 16'(step_id);
        sq.push_back(x);
    endtask

    task automatic t_s(input logic [7:0] d, input logic [3:0] t, input logic [3:0] o,
                       input logic v, input logic e, input logic l);
        step(2'b01, d, t, o, v, e, l, 1'b0);
    endtask

    task automatic o_s(input logic [7:0] d, input logic [3:0] t, input logic [3:0] o,
                       input logic v, input logic e, input logic l);
        step(2'b10, d, t, o, v, e, l, 1'b0);
    endtask

    initial begin
        logic [6:0] seg_tab [10];
        logic [3:0] exp_one;
        int         n;

        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;

        rsta_n   = 1'b0;
        rstb_n   = 1'b0;
        Scan_Sig = 2'b11;
        SMG_Data = 8'hFF;
        repeat (3) @(negedge CLK);
        rsta_n = 1'b1;
        #1;
        chk("rst_ten",  0, int'(a_ten),  0);
        chk("rst_one",  0, int'(a_one),  0);
        chk("rst_dv",   0, int'(a_dv),   0);
        chk("rst_err",  0, int'(a_err),  0);
        chk("rst_lost", 0, int'(a_lost), 0);

        // Tens=2 (A4), ones=5 (92): commits on 4th sample, DV one cycle later.
        for (int k = 1; k <= 4; k++) begin
            t_s(8'hA4, (k == 4) ? 4'd2 : 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            o_s(8'h92, (k == 4) ? 4'd2 : 4'd0, (k == 4) ? 4'd5 : 4'd0, 1'b0, 1'b0, 1'b0);
        end

        // Commit 3, hold through more B0, then 4 on the 4th 99.
        for (int k = 1; k <= 4; k++) begin
            t_s(8'hB0, (k == 4) ? 4'd3 : 4'd2, 4'd5, 1'b1, 1'b0, 1'b0);
            o_s(8'h92, (k == 4) ? 4'd3 : 4'd2, 4'd5, 1'b1, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 3; k++) begin
            t_s(8'hB0, 4'd3, 4'd5, 1'b1, 1'b0, 1'b0);
            o_s(8'h92, 4'd3, 4'd5, 1'b1, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 4; k++) begin
            t_s(8'h99, (k == 4) ? 4'd4 : 4'd3, 4'd5, 1'b1, 1'b0, 1'b0);
            o_s(8'h92, (k == 4) ? 4'd4 : 4'd3, 4'd5, 1'b1, 1'b0, 1'b0);
        end

        // Two A4 samples, then illegal FF and a select conflict: the tens
        // count must restart, so four more A4 samples are needed to commit 2.
        for (int k = 1; k <= 2; k++) begin
            t_s(8'hA4, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
            o_s(8'h92, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
        end
        t_s(8'hFF, 4'd4, 4'd5, 1'b1, 1'b1, 1'b0);
        step(2'b00, 8'hA4, 4'd4, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        o_s(8'h92, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            t_s(8'hA4, (k == 4) ? 4'd2 : 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
            o_s(8'h92, (k == 4) ? 4'd2 : 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
        end

        // Ones scan stops: loss on the 16th cycle after the last ones sample.
        for (int k = 1; k <= 17; k++) begin
            t_s(8'hA4, 4'd2, 4'd5, (k >= 16) ? 1'b0 : 1'b1, 1'b0, (k >= 16) ? 1'b1 : 1'b0);
        end
        // Resume with ones=C0 (0): loss clears at once, DV after 4 samples + 1.
        for (int k = 1; k <= 4; k++) begin
            o_s(8'hC0, 4'd2, (k == 4) ? 4'd0 : 4'd5, 1'b0, 1'b0, 1'b0);
            t_s(8'hA4, 4'd2, (k == 4) ? 4'd0 : 4'd5, (k == 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        end

        // Tens candidate 4 at count 3, then asynchronous reset between edges.
        for (int k = 1; k <= 3; k++) begin
            t_s(8'h99, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
            o_s(8'hC0, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
        end
        @(posedge CLK);
        #3;
        Scan_Sig = 2'b11;
        rsta_n   = 1'b0;
        #1;
        chk("arst_ten",  0, int'(a_ten),  0);
        chk("arst_one",  0, int'(a_one),  0);
        chk("arst_dv",   0, int'(a_dv),   0);
        chk("arst_err",  0, int'(a_err),  0);
        chk("arst_lost", 0, int'(a_lost), 0);
        @(negedge CLK);
        rsta_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            t_s(8'h99, (k == 4) ? 4'd4 : 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            o_s(8'h92, (k == 4) ? 4'd4 : 4'd0, (k == 4) ? 4'd5 : 4'd0, 1'b0, 1'b0, 1'b0);
        end
        t_s(8'h99, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);

        // Instance B (STABLE_CNT=1): every legal code, DP 0/1, on both digits.
        @(negedge CLK);
        Scan_Sig = 2'b11;
        rstb_n   = 1'b1;
        #1;
        chk("b_rst_ten", 0, int'(b_ten), 0);
        chk("b_rst_dv",  0, int'(b_dv),  0);
        exp_one = 4'd0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            for (int dp = 0; dp < 2; dp++) begin
                n++;
                step(2'b01, {dp[0], seg_tab[i]}, 4'(i), exp_one, (n >= 3), 1'b0, 1'b0, 1'b1);
                exp_one = 4'(9 - i);
                n++;
                step(2'b10, {dp[0], seg_tab[9 - i]}, 4'(i), exp_one, (n >= 3), 1'b0, 1'b0, 1'b1);
            end
        end

        @(posedge CLK);
        #3;
        if (sq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
